ioctl_sdram_loader: RTL and testbench

- Generalised ROM download controller between data_io (ioctl_* byte stream) and one toggle-handshake SDRAM write port (port1_req/port1_ack style).
- Filters one ioctl_index and packs bytes into BYTES-wide words.
- Buffers packed words in a small FIFO and issues one handshaked SDRAM write per word.
- Reports busy, overflow and a rom_loaded flag that sets once the last word is acknowledged.

---
 rtl/ioctl_sdram_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_ioctl_sdram_loader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_sdram_loader.sv
// Packs a filtered ioctl byte stream into BYTES-wide words, buffers them and writes each one
// through a toggle-handshake SDRAM port. Define IOCTL_LOADER_CHECKSUM_EN to add a byte checksum.
module ioctl_sdram_loader #(
    parameter int unsigned AW         = 23,
    parameter int unsigned BYTES      = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  INDEX      = 8'd0,
    parameter int unsigned BASE       = 0
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic [AW-1:0]        mem_addr,
    output logic [8*BYTES-1:0]   mem_din,
    output logic [BYTES-1:0]     mem_be,
    output logic                 mem_we,
    output logic                 busy,
    output logic                 rom_loaded,
`ifdef IOCTL_LOADER_CHECKSUM_EN
    output logic [15:0]          checksum,
    output logic                 checksum_valid,
`endif
    output logic                 overflow
);

    localparam int unsigned LB = (BYTES == 4) ? 2 : (BYTES == 2) ? 1 : 0;
    localparam int unsigned DW = 8 * BYTES;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = AW + DW + BYTES;
    localparam logic [PW:0] PtrOne = (PW + 1)'(1);

    typedef enum logic [1:0] {StSync, StIdle, StWait} state_e;

    logic              wr_q, dl_q, seen_q, done_q;
    logic [AW-1:0]     asm_addr_q, asm_addr_d;
    logic [DW-1:0]     asm_data_q, asm_data_d;
    logic [BYTES-1:0]  asm_be_q, asm_be_d;
    logic              idx_match, accept, dl_fall, partial, last_lane, new_word;
    logic [1:0]        lane;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     merge_data;
    logic [BYTES-1:0]  merge_be;
    logic              push, push_ok, pop;
    logic [EW-1:0]     push_word, head_word;
    logic [EW-1:0]     fifo_q [FIFO_DEPTH];
    logic [PW:0]       wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full;
    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_din_q, mem_din_d;
    logic [BYTES-1:0]  mem_be_q, mem_be_d;
    logic              busy_q, busy_d, rom_loaded_q, rom_loaded_d, overflow_q, overflow_d;
    logic              unused_addr;

    assign unused_addr = ^ioctl_addr;

    if (LB == 0) begin : g_lane_none
        assign lane = 2'd0;
    end else begin : g_lane
        assign lane = 2'(ioctl_addr[LB-1:0]);
    end

    assign waddr     = ioctl_addr[AW+LB-1:LB] + AW'(BASE);
    assign idx_match = (ioctl_index == INDEX);
    assign accept    = ioctl_wr & ~wr_q & ioctl_download & idx_match;
    assign dl_fall   = dl_q & ~ioctl_download;
    assign partial   = |asm_be_q;
    assign last_lane = (lane == 2'(BYTES - 1));
    assign new_word  = partial & (waddr != asm_addr_q);

    // A byte for a different word starts from an empty register after the old one is pushed.
    always_comb begin
        merge_data = new_word ? '0 : asm_data_q;
        merge_be   = new_word ? '0 : asm_be_q;
        for (int k = 0; k < BYTES; k++) begin
            if (lane == 2'(k)) begin
                merge_data[8*k +: 8] = ioctl_dout;
                merge_be[k]          = 1'b1;
            end
        end
    end

    always_comb begin
        push       = 1'b0;
        push_word  = {asm_addr_q, asm_data_q, asm_be_q};
        asm_addr_d = asm_addr_q;
        asm_data_d = asm_data_q;
        asm_be_d   = asm_be_q;
        if (accept) begin
            asm_addr_d = waddr;
            asm_data_d = merge_data;
            asm_be_d   = merge_be;
            if (new_word) begin
                push = 1'b1;
            end else if (last_lane) begin
                push       = 1'b1;
                push_word  = {waddr, merge_data, merge_be};
                asm_addr_d = '0;
                asm_data_d = '0;
                asm_be_d   = '0;
            end
        end else if (dl_fall && partial) begin
            push       = 1'b1;
            asm_addr_d = '0;
            asm_data_d = '0;
            asm_be_d   = '0;
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head_word  = fifo_q[rd_ptr_q[PW-1:0]];
    // A pop frees the slot this cycle, so a push on full still fits.
    assign push_ok    = push & (~fifo_full | pop);

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_be_d   = mem_be_q;
        unique case (state_q)
            StSync: begin
                if (mem_ack == mem_req_q) state_d = StIdle;
            end
            StIdle: begin
                if (!fifo_empty) begin
                    pop                                = 1'b1;
                    {mem_addr_d, mem_din_d, mem_be_d}  = head_word;
                    mem_req_d                          = ~mem_req_q;
                    mem_we_d                           = 1'b1;
                    state_d                            = StWait;
                end
            end
            StWait: begin
                if (mem_ack == mem_req_q) begin
                    mem_we_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StSync;
        endcase
    end

    assign busy_d       = (ioctl_download & idx_match) | ~fifo_empty | (state_q != StIdle) |
                          partial;
    assign rom_loaded_d = rom_loaded_q |
                          (done_q & fifo_empty & ~partial & (state_q == StIdle));
    assign overflow_d   = overflow_q | (push & fifo_full & ~pop);

    always_ff @(posedge clk_sys) begin
        if (push_ok) fifo_q[wr_ptr_q[PW-1:0]] <= push_word;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_q         <= 1'b0;
            dl_q         <= 1'b0;
            seen_q       <= 1'b0;
            done_q       <= 1'b0;
            asm_addr_q   <= '0;
            asm_data_q   <= '0;
            asm_be_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= StSync;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_be_q     <= '0;
            busy_q       <= 1'b0;
            rom_loaded_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_q         <= ioctl_wr;
            dl_q         <= ioctl_download;
            if (ioctl_download && idx_match) seen_q <= 1'b1;
            else if (dl_fall) seen_q <= 1'b0;
            if (dl_fall && seen_q) done_q <= 1'b1;
            asm_addr_q   <= asm_addr_d;
            asm_data_q   <= asm_data_d;
            asm_be_q     <= asm_be_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_be_q     <= mem_be_d;
            busy_q       <= busy_d;
            rom_loaded_q <= rom_loaded_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef IOCTL_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge clk_sys) begin
        if (reset) checksum_q <= '0;
        else if (accept) checksum_q <= checksum_q + {8'h00, ioctl_dout};
    end

    assign checksum       = checksum_q;
    assign checksum_valid = rom_loaded_q;
`endif

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_be     = mem_be_q;
    assign busy       = busy_q;
    assign rom_loaded = rom_loaded_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Scoreboard bench for ioctl_sdram_loader: expected words come from grouping downloaded bytes
// by word address; a responder process acks requests and checks each write against the queue.
module tb_ioctl_sdram_loader;

    localparam int         AW    = 23;
    localparam int         BYTES = 2;
    localparam int         FD    = 2;
    localparam int         BASE  = 0;
    localparam logic [7:0] INDEX = 8'd0;

    typedef struct {
        logic [AW-1:0]      addr;
        logic [8*BYTES-1:0] din;
        logic [BYTES-1:0]   be;
    } word_t;

    logic                clk_sys = 1'b0;
    logic                reset = 1'b1;
    logic                ioctl_download = 1'b0;
    logic [7:0]          ioctl_index = 8'd0;
    logic                ioctl_wr = 1'b0;
    logic [24:0]         ioctl_addr = '0;
    logic [7:0]          ioctl_dout = 8'd0;
    logic                mem_req;
    logic                mem_ack = 1'b0;
    logic [AW-1:0]       mem_addr;
    logic [8*BYTES-1:0]  mem_din;
    logic [BYTES-1:0]    mem_be;
    logic                mem_we, busy, rom_loaded, overflow;
`ifdef IOCTL_LOADER_CHECKSUM_EN
    logic [15:0]         checksum;
    logic                checksum_valid;
`endif

    ioctl_sdram_loader #(
        .AW(AW), .BYTES(BYTES), .FIFO_DEPTH(FD), .INDEX(INDEX), .BASE(BASE)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_be(mem_be), .mem_we(mem_we), .busy(busy),
        .rom_loaded(rom_loaded),
`ifdef IOCTL_LOADER_CHECKSUM_EN
        .checksum(checksum), .checksum_valid(checksum_valid),
`endif
        .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int                 vectors = 0;
    int                 miscompares = 0;
    word_t              exp_q[$];
    logic [7:0]         dl_data[$];
    bit                 resp_en = 1'b1;
    bit                 ack_hold = 1'b0;
    int                 fixed_delay = -1;
    bit                 pending = 1'b0;
    int                 dly_cnt = 0;
    int                 req_count = 0;
    logic [AW-1:0]      lat_addr;
    logic [8*BYTES-1:0] lat_din;
    logic [BYTES-1:0]   lat_be;
    bit                 rom_model = 1'b0;
    bit                 ovf_model = 1'b0;
    logic [15:0]        cksum_model = '0;
    bit                 track_busy = 1'b0;
    bit                 busy_seen = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_write();
        word_t              e;
        logic [8*BYTES-1:0] mask;
        check("write_we", 32'(mem_we), 1);
        check("stable_addr", 32'(mem_addr), 32'(lat_addr));
        check("stable_din", 32'(mem_din), 32'(lat_din));
        check("stable_be", 32'(mem_be), 32'(lat_be));
        if (exp_q.size() == 0) begin
            check("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
            return;
        end
        e    = exp_q.pop_front();
        mask = '0;
        for (int k = 0; k < BYTES; k++) if (e.be[k]) mask[8*k +: 8] = 8'hFF;
        check("write_addr", 32'(mem_addr), 32'(e.addr));
        check("write_din", 32'(mem_din & mask), 32'(e.din & mask));
        check("write_be", 32'(mem_be), 32'(e.be));
    endfunction

    // Responder and monitor: acks each toggle after a delay and scores the write.
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            if (resp_en && !reset && (mem_req != mem_ack)) begin
                if (!pending) begin
                    pending  = 1'b1;
                    lat_addr = mem_addr;
                    lat_din  = mem_din;
                    lat_be   = mem_be;
                    dly_cnt  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                    req_count++;
                end
                if (!ack_hold) begin
                    if (dly_cnt > 0) dly_cnt--;
                    else begin
                        check_write();
                        mem_ack = mem_req;
                        pending = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk_sys) if (track_busy && busy) busy_seen = 1'b1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    // Reference: every byte address in range lands in word addr/BYTES, lane addr%BYTES.
    function automatic void model_push(input int start, input int len, input logic [7:0] idx,
                                       input int max_words);
        word_t e;
        int    nw = 0;
        if (idx != INDEX) return;
        for (int w = start / BYTES; w <= (start + len - 1) / BYTES; w++) begin
            e.addr = AW'(w + BASE);
            e.din  = '0;
            e.be   = '0;
            for (int k = 0; k < BYTES; k++) begin
                int a = w * BYTES + k;
                if (a >= start && a < start + len) begin
                    e.din[8*k +: 8] = dl_data[a - start];
                    e.be[k]         = 1'b1;
                end
            end
            if (max_words < 0 || nw < max_words) exp_q.push_back(e);
            nw++;
        end
        for (int i = 0; i < len; i++) cksum_model += {8'h00, dl_data[i]};
    endfunction

    task automatic fill_random(input int len);
        dl_data.delete();
        for (int i = 0; i < len; i++) dl_data.push_back(8'($urandom));
    endtask

    task automatic send_byte(input int a, input logic [7:0] d, input int hold, input int gap);
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        repeat (hold) @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
        repeat (gap) @(posedge clk_sys);
        #1;
    endtask

    task automatic download(input int start, input int len, input logic [7:0] idx,
                            input int hold, input int gap, input int max_words);
        model_push(start, len, idx, max_words);
        @(posedge clk_sys);
        #1;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        for (int i = 0; i < len; i++) send_byte(start + i, dl_data[i], hold, gap);
        ioctl_download = 1'b0;
        if (idx == INDEX) rom_model = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    task automatic check_cksum(input string name);
`ifdef IOCTL_LOADER_CHECKSUM_EN
        check({"checksum_", name}, 32'(checksum), 32'(cksum_model));
        check({"checksum_valid_", name}, 32'(checksum_valid), 32'(rom_model));
`else
        if (name.len() == 0) $display("unnamed step");
`endif
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || pending || busy) && n < 3000) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        check({"drain_", name}, 32'(n < 3000), 1);
        repeat (3) @(posedge clk_sys);
        #1;
        check({"rom_loaded_", name}, 32'(rom_loaded), 32'(rom_model));
        check({"overflow_", name}, 32'(overflow), 32'(ovf_model));
        check_cksum(name);
    endtask

    task automatic do_reset(input logic ack);
        @(posedge clk_sys);
        #1;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        mem_ack        = ack;
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rom_loaded", 32'(rom_loaded), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_din", 32'(mem_din), 0);
        check("rst_mem_be", 32'(mem_be), 0);
        exp_q.delete();
        pending     = 1'b0;
        rom_model   = 1'b0;
        ovf_model   = 1'b0;
        cksum_model = '0;
        reset       = 1'b0;
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        int req0;

        // Basic four-byte download with a fixed three-cycle ack.
        do_reset(1'b0);
        fixed_delay = 3;
        dl_data     = '{8'h11, 8'h22, 8'h33, 8'h44};
        download(0, 4, INDEX, 1, 3, -1);
        wait_idle("basic");

        // Odd length leaves a one-byte tail flushed at download end.
        do_reset(1'b0);
        fill_random(5);
        download(0, 5, INDEX, 1, 3, -1);
        wait_idle("odd_len");

        // Foreign index: nothing written, never busy, never loaded.
        do_reset(1'b0);
        repeat (3) @(posedge clk_sys);
        #1;
        req0       = req_count;
        busy_seen  = 1'b0;
        track_busy = 1'b1;
        fill_random(8);
        download(0, 8, 8'd1, 1, 2, -1);
        repeat (10) @(posedge clk_sys);
        #1;
        track_busy = 1'b0;
        check("foreign_busy", 32'(busy_seen), 0);
        check("foreign_requests", 32'(req_count - req0), 0);
        check("foreign_rom_loaded", 32'(rom_loaded), 0);

        // Ack held off while eight complete words arrive: only 1 + FD survive.
        do_reset(1'b0);
        fixed_delay = 1;
        ack_hold    = 1'b1;
        fill_random(16);
        download(0, 16, INDEX, 1, 1, 1 + FD);
        ovf_model = (8 > 1 + FD);
        check("overflow_held", 32'(overflow), 32'(ovf_model));
        ack_hold = 1'b0;
        wait_idle("overflow");

        // Strobe held high four cycles per byte, odd start address.
        do_reset(1'b0);
        fixed_delay = -1;
        fill_random(6);
        download(1, 6, INDEX, 4, 2, -1);
        wait_idle("long_strobe");

        // Randomised downloads back to back without reset.
        for (int t = 0; t < 12; t++) begin
            int         st  = int'($urandom_range(0, 40));
            int         ln  = int'($urandom_range(1, 9));
            int         hd  = int'($urandom_range(1, 4));
            logic [7:0] idx = ($urandom_range(0, 3) == 0) ? 8'd1 : INDEX;
            fill_random(ln);
            download(st, ln, idx, hd, 5, -1);
            wait_idle("random");
        end

        // Reset mid-transfer with ack left high: no request until ack returns low.
        do_reset(1'b0);
        fixed_delay = 8;
        fill_random(4);
        model_push(0, 4, INDEX, -1);
        @(posedge clk_sys);
        #1;
        ioctl_index    = INDEX;
        ioctl_download = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(i, dl_data[i], 1, 3);
        resp_en = 1'b0;
        do_reset(1'b1);
        repeat (5) @(posedge clk_sys);
        #1;
        check("sync_req", 32'(mem_req), 0);
        check("sync_busy", 32'(busy), 1);
        fill_random(4);
        download(8, 4, INDEX, 1, 3, -1);
        repeat (10) @(posedge clk_sys);
        #1;
        check("sync_hold_req", 32'(mem_req), 0);
        check("sync_hold_we", 32'(mem_we), 0);
        mem_ack     = 1'b0;
        fixed_delay = -1;
        resp_en     = 1'b1;
        wait_idle("reset_recover");

`ifdef IOCTL_LOADER_CHECKSUM_EN
        do_reset(1'b0);
        dl_data = '{8'hFF, 8'h02};
        download(0, 2, INDEX, 1, 3, -1);
        wait_idle("cksum");
        check("checksum_ff02", 32'(checksum), 32'h0101);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
